gshare_predictor: RTL and testbench
===================================

GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

Interface
REQ-001 SHALL have parameter GHSR_W, default 10, global history width.
REQ-002 SHALL have parameter PHT_ENTRIES, default 1024, pattern-history-table depth; power of two; IDX_W = log2(PHT_ENTRIES); GHSR_W <= IDX_W.
REQ-003 SHALL have parameter CTR_W, default 2, saturating-counter width (2..4).
REQ-004 SHALL have parameter XLEN, default 32, PC width.
REQ-005 SHALL have one clock; reset is synchronous and active-high: clk  in  1  rising-edge clock.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 predict_req  in  1  IF-stage lookup request, one per cycle max.
REQ-008 predict_pc  in  XLEN  PC being fetched.
REQ-009 predict_taken  out  1  combinational prediction for predict_pc.
REQ-010 predict_ghsr  out  GHSR_W  history snapshot used for this lookup; carried down the pipe.
REQ-011 update_valid  in  1  EX-stage resolved conditional branch.
REQ-012 update_pc  in  XLEN  PC of resolved branch.
REQ-013 update_ghsr  in  GHSR_W  snapshot returned from the lookup.
REQ-014 update_taken  in  1  actual outcome.
REQ-015 update_mispredict  in  1  predicted outcome differed from actual.
REQ-016 ready  out  1  table initialised, predictions valid.
REQ-017 mispredict_count  out  32  saturating count of qualified mispredicts.

Function
REQ-018 Index SHALL be {zero-ext GHSR} XOR pc[IDX_W+1:2], for lookup (live GHSR, predict_pc) and update (update_ghsr, update_pc).
REQ-019 predict_taken SHALL equal MSB of the indexed counter when ready=1; 0 when ready=0.
REQ-020 predict_ghsr SHALL equal the current GHSR register (same cycle, combinational).
REQ-021 FSM SHALL have states INIT and RUN; reset -> INIT.
REQ-022 INIT: a counter walks 0..PHT_ENTRIES-1, writing weak-not-taken (2^(CTR_W-1)-1) to one entry per cycle; after the last entry -> RUN; ready=1 only in RUN.
REQ-023 In INIT, predict_req and update_valid SHALL be ignored: no GHSR change, no counter change, no mispredict count.
REQ-024 RUN, predict_req=1, no mispredict: GHSR <= {GHSR[GHSR_W-2:0], predict_taken}.
REQ-025 RUN, update_valid=1: indexed counter increments if update_taken else decrements, saturating at 2^CTR_W-1 and 0.
REQ-026 RUN, update_valid=1 and update_mispredict=1: GHSR <= {update_ghsr[GHSR_W-2:0], update_taken}; this overrides a same-cycle predict_req shift.
REQ-027 A same-cycle update and lookup to the same index: lookup sees the pre-update value; the write is visible the next cycle (no bypass).
REQ-028 mispredict_count SHALL increment on each RUN cycle with update_valid and update_mispredict, holding at 0xFFFFFFFF.
REQ-029 update_mispredict with update_valid=0 SHALL have no effect.

Reset
REQ-030 On reset: state=INIT, init index=0, GHSR=0, ready=0, predict_taken=0, mispredict_count=0; the PHT is rewritten only by the INIT sweep.
REQ-031 Reset asserted mid-INIT or mid-RUN SHALL restart the sweep at index 0, giving a full PHT_ENTRIES cycles before ready.

Structure
REQ-032 The shared package SHALL hold GSHARE_GHSR_WIDTH, GSHARE_PHT_SIZE, the counter reset constant, and a parametrised gshare index function; the existing fixed-width hash is superseded.
REQ-033 PHT storage SHALL be sub-module gshare_pht: one async-read port, one sync-write port, with write-mux between sweep and update.

Verification
REQ-034 Reset 1 cycle, defaults -> ready=0 for 1024 cycles, ready=1 on cycle 1025, predict_taken=0 for any PC, predict_ghsr=0x000.
REQ-035 Train: two updates pc=0x100, ghsr=0x000, taken=1 -> counter 01->10->11; lookup pc=0x100 with GHSR=0 gives predict_taken=1.
REQ-036 Saturation: five taken updates then five not-taken on the same index -> counter 11, stays 11, then reaches 00 and stays 00; prediction 0.
REQ-037 Speculation: GHSR=0, three predict_req with predict_taken 1,0,1 -> GHSR=0x005.
REQ-038 Recovery: predict_req and update (mispredict=1, update_ghsr=0x0A0, taken=1) in the same cycle -> GHSR=0x141 next cycle; mispredict_count +1.
REQ-039 Reset asserted at INIT cycle 500 -> ready stays 0 for another 1024 cycles; an update issued during INIT leaves the counter at 01.

Source files
------------

// File: rtl/gshare_predictor_pkg.sv
// Shared definitions for the gshare branch predictor.
//   GSHARE_GHSR_WIDTH  default global-history width
//   GSHARE_PHT_SIZE    default pattern-history-table depth
//   GSHARE_CTR_WIDTH   default saturating-counter width
//   GSHARE_CTR_RESET   weak-not-taken value for the default counter width
//   gshare_state_t     predictor FSM state (INIT sweep / RUN)
//   gshare_ctr_reset() weak-not-taken value for any counter width
//   gshare_index()     table index: zero-extended history XOR pc[idx_w+1:2]
package gshare_predictor_pkg;

    localparam int GSHARE_GHSR_WIDTH = 10;
    localparam int GSHARE_PHT_SIZE   = 1024;
    localparam int GSHARE_CTR_WIDTH  = 2;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } gshare_state_t;

    // Weak-not-taken: 2^(ctr_w-1)-1, i.e. MSB clear, all lower bits set.
    function automatic logic [3:0] gshare_ctr_reset(input int ctr_w);
        return 4'((1 << (ctr_w - 1)) - 1);
    endfunction

    localparam logic [GSHARE_CTR_WIDTH-1:0] GSHARE_CTR_RESET =
        GSHARE_CTR_WIDTH'(gshare_ctr_reset(GSHARE_CTR_WIDTH));

    // The PC is word aligned, so the two LSBs carry no information and are
    // dropped before hashing. The caller truncates the result to idx_w bits.
    function automatic logic [31:0] gshare_index(input logic [31:0] ghsr,
                                                 input logic [63:0] pc,
                                                 input int          idx_w);
        logic [63:0] mask;
        mask = (64'd1 << idx_w) - 64'd1;
        return 32'((64'(ghsr) ^ (pc >> 2)) & mask);
    endfunction

endpackage

// File: rtl/gshare_predictor_if.sv
// Lookup/update bus of the gshare predictor.
//   predict_req/pc      -> lookup strobe and fetch PC
//   predict_taken/ghsr  <- combinational prediction and history snapshot
//   update_*            -> resolved-branch training from EX
//   ready               <- table initialised
//   mispredict_count    <- saturating count of qualified mispredicts
//
// Handshake: there is no backpressure. predict_req and update_valid are
// single-cycle strobes that are acted on in the cycle they are high, and
// only while ready=1; while ready=0 they are dropped without effect.
// ready is a level, not a per-transaction acknowledge.
interface gshare_predictor_if #(
    parameter int XLEN   = 32,
    parameter int GHSR_W = 10
);
    logic              predict_req;
    logic [XLEN-1:0]   predict_pc;
    logic              predict_taken;
    logic [GHSR_W-1:0] predict_ghsr;
    logic              update_valid;
    logic [XLEN-1:0]   update_pc;
    logic [GHSR_W-1:0] update_ghsr;
    logic              update_taken;
    logic              update_mispredict;
    logic              ready;
    logic [31:0]       mispredict_count;

    modport master (
        output predict_req, predict_pc,
               update_valid, update_pc, update_ghsr, update_taken, update_mispredict,
        input  predict_taken, predict_ghsr, ready, mispredict_count
    );

    modport slave (
        input  predict_req, predict_pc,
               update_valid, update_pc, update_ghsr, update_taken, update_mispredict,
        output predict_taken, predict_ghsr, ready, mispredict_count
    );
endinterface

// File: rtl/gshare_pht.sv
// Pattern history table of saturating counters.
//   rd_idx/rd_ctr       async lookup read port
//   init_we/init_idx    sweep write of the weak-not-taken value
//   upd_we/upd_idx/
//   upd_taken           training write: read-modify-write saturating step
// The two writers share one synchronous write port; the sweep wins, and the
// top never asserts both at once.
module gshare_pht
    import gshare_predictor_pkg::*;
#(
    parameter int ENTRIES = 1024,
    parameter int IDX_W   = 10,
    parameter int CTR_W   = 2
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CTR_W-1:0] rd_ctr,
    input  logic             init_we,
    input  logic [IDX_W-1:0] init_idx,
    input  logic             upd_we,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(gshare_ctr_reset(CTR_W));
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;

    logic [CTR_W-1:0] mem [ENTRIES];
    logic [CTR_W-1:0] upd_old;
    logic [CTR_W-1:0] upd_new;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [CTR_W-1:0] wr_data;

    // Lookup sees the stored value; a same-cycle write lands at the edge.
    assign rd_ctr = mem[rd_idx];

    always_comb begin
        upd_old = mem[upd_idx];
        upd_new = upd_old;
        if (upd_taken && upd_old != CTR_MAX) begin
            upd_new = upd_old + CTR_W'(1);
        end else if (!upd_taken && upd_old != '0) begin
            upd_new = upd_old - CTR_W'(1);
        end
    end

    always_comb begin
        wr_en   = upd_we;
        wr_idx  = upd_idx;
        wr_data = upd_new;
        if (init_we) begin
            wr_en   = 1'b1;
            wr_idx  = init_idx;
            wr_data = CTR_INIT;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare conditional-branch predictor.
//   clk, reset   rising-edge clock, synchronous active-high reset
//   bus          gshare_predictor_if slave (lookup, update, ready, count)
//   state_dbg    current FSM state (INIT sweep or RUN)
// After reset the table is swept to weak-not-taken, one entry per cycle;
// only then does the predictor accept lookups and training.
module gshare_predictor
    import gshare_predictor_pkg::*;
#(
    parameter int GHSR_W      = GSHARE_GHSR_WIDTH,
    parameter int PHT_ENTRIES = GSHARE_PHT_SIZE,
    parameter int CTR_W       = GSHARE_CTR_WIDTH,
    parameter int XLEN        = 32
) (
    input  logic          clk,
    input  logic          reset,
    gshare_predictor_if.slave bus,
    output gshare_state_t state_dbg
);

    localparam int IDX_W = $clog2(PHT_ENTRIES);

    gshare_state_t     state_q;
    logic [IDX_W-1:0]  init_idx_q;
    logic [GHSR_W-1:0] ghsr_q;
    logic [31:0]       count_q;

    logic              run;
    logic [IDX_W-1:0]  lookup_idx;
    logic [IDX_W-1:0]  update_idx;
    logic [CTR_W-1:0]  lookup_ctr;
    logic              taken;
    logic              recover;

    assign run        = (state_q == ST_RUN);
    assign lookup_idx = IDX_W'(gshare_index(32'(ghsr_q), 64'(bus.predict_pc), IDX_W));
    assign update_idx = IDX_W'(gshare_index(32'(bus.update_ghsr), 64'(bus.update_pc), IDX_W));
    assign taken      = run & lookup_ctr[CTR_W-1];
    assign recover    = run & bus.update_valid & bus.update_mispredict;

    assign bus.predict_taken    = taken;
    assign bus.predict_ghsr     = ghsr_q;
    assign bus.ready            = run;
    assign bus.mispredict_count = count_q;
    assign state_dbg            = state_q;

    gshare_pht #(
        .ENTRIES (PHT_ENTRIES),
        .IDX_W   (IDX_W),
        .CTR_W   (CTR_W)
    ) u_pht (
        .clk       (clk),
        .rd_idx    (lookup_idx),
        .rd_ctr    (lookup_ctr),
        .init_we   (!run && !reset),
        .init_idx  (init_idx_q),
        .upd_we    (run && bus.update_valid),
        .upd_idx   (update_idx),
        .upd_taken (bus.update_taken)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_INIT;
            init_idx_q <= '0;
            ghsr_q     <= '0;
            count_q    <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    init_idx_q <= init_idx_q + IDX_W'(1);
                    if (init_idx_q == IDX_W'(PHT_ENTRIES - 1)) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // A resolved mispredict rebuilds history from the snapshot
                    // the branch carried, discarding any younger speculation.
                    if (recover) begin
                        ghsr_q <= GHSR_W'({bus.update_ghsr, bus.update_taken});
                        if (count_q != 32'hFFFF_FFFF) begin
                            count_q <= count_q + 32'd1;
                        end
                    end else if (bus.predict_req) begin
                        ghsr_q <= GHSR_W'({ghsr_q, taken});
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor.
module tb_gshare_predictor;
    import gshare_predictor_pkg::*;

    localparam int GHSR_W = 10;
    localparam int PHT    = 1024;
    localparam int CTR_W  = 2;
    localparam int XLEN   = 32;
    localparam int HALF   = 1 << (CTR_W - 1);
    localparam int CMAX   = (1 << CTR_W) - 1;
    localparam int EXP_W  = 2 + GHSR_W + 32;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst;
    gshare_state_t state_dbg;

    always #5 clk = ~clk;

    gshare_predictor_if #(.XLEN(XLEN), .GHSR_W(GHSR_W)) bus ();

    gshare_predictor #(
        .GHSR_W      (GHSR_W),
        .PHT_ENTRIES (PHT),
        .CTR_W       (CTR_W),
        .XLEN        (XLEN)
    ) dut (
        .clk       (clk),
        .reset     (rst),
        .bus       (bus.slave),
        .state_dbg (state_dbg)
    );

    // ---------------- reference model ----------------
    int                n_checks = 0;
    int                n_errors = 0;
    logic [EXP_W-1:0]  exp_q[$];
    int                m_pht[PHT];
    logic [GHSR_W-1:0] m_ghsr;
    logic              m_ready;
    int                m_init;
    logic [31:0]       m_count;

    function automatic int pht_index(input logic [GHSR_W-1:0] g, input logic [XLEN-1:0] pc);
        return (int'(g) ^ int'(pc >> 2)) & (PHT - 1);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        bus.predict_req  = 1'b0;
        bus.update_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        m_ghsr  = '0;
        m_ready = 1'b0;
        m_init  = 0;
        m_count = '0;
    endtask

    // One clock of stimulus; expected lookup response is queued, then the
    // model advances by the rules for this cycle.
    task automatic step(input bit req, input logic [XLEN-1:0] pc,
                        input bit uv, input logic [XLEN-1:0] upc,
                        input logic [GHSR_W-1:0] ug, input bit ut, input bit um);
        bit exp_t;
        int ui;
        bus.predict_req       = req;
        bus.predict_pc        = pc;
        bus.update_valid      = uv;
        bus.update_pc         = upc;
        bus.update_ghsr       = ug;
        bus.update_taken      = ut;
        bus.update_mispredict = um;
        exp_t = m_ready && (m_pht[pht_index(m_ghsr, pc)] >= HALF);
        if (req) exp_q.push_back({m_ready, exp_t, m_ghsr, m_count});
        if (!m_ready) begin
            m_pht[m_init] = HALF - 1;
            m_init++;
            if (m_init == PHT) m_ready = 1'b1;
        end else begin
            if (uv) begin
                ui = pht_index(ug, upc);
                if (ut && m_pht[ui] < CMAX) m_pht[ui]++;
                if (!ut && m_pht[ui] > 0) m_pht[ui]--;
            end
            if (uv && um) begin
                m_ghsr = GHSR_W'((int'(ug) << 1) | int'(ut));
                if (m_count != 32'hFFFF_FFFF) m_count++;
            end else if (req) begin
                m_ghsr = GHSR_W'((int'(m_ghsr) << 1) | int'(exp_t));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, '0, '0, 0, 0);
    endtask

    // Lookup whose index (under the current history) is t.
    task automatic lookup_at(input int t);
        step(1, XLEN'(((t ^ int'(m_ghsr)) & (PHT - 1)) << 2), 0, '0, '0, 0, 0);
    endtask

    task automatic update_at(input int t, input bit ut, input bit um, input logic [GHSR_W-1:0] ug);
        step(0, '0, 1, XLEN'(((t ^ int'(ug)) & (PHT - 1)) << 2), ug, ut, um);
    endtask

    task automatic random_step();
        step(1'($urandom_range(0, 1)), XLEN'($urandom_range(0, 63) << 2),
             1'($urandom_range(0, 1)), XLEN'($urandom_range(0, 63) << 2),
             GHSR_W'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3) == 0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.predict_req === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_underflow: lookup seen with no expected entry at %0t", $time);
            end else begin
                logic [EXP_W-1:0] e;
                e = exp_q.pop_front();
                check("lookup_ready", 64'(bus.ready), 64'(e[EXP_W-1]));
                check("lookup_taken", 64'(bus.predict_taken), 64'(e[EXP_W-2]));
                check("lookup_ghsr", 64'(bus.predict_ghsr), 64'(e[EXP_W-3 -: GHSR_W]));
                check("lookup_count", 64'(bus.mispredict_count), 64'(e[31:0]));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.predict_req       = 1'b0;
        bus.predict_pc        = '0;
        bus.update_valid      = 1'b0;
        bus.update_pc         = '0;
        bus.update_ghsr       = '0;
        bus.update_taken      = 1'b0;
        bus.update_mispredict = 1'b0;
        rst = 1'b1;
        do_reset();

        check("rst_ready", 64'(bus.ready), 64'(0));
        check("rst_count", 64'(bus.mispredict_count), 64'(0));
        check("rst_ghsr", 64'(bus.predict_ghsr), 64'(0));
        check("rst_taken", 64'(bus.predict_taken), 64'(0));
        check("rst_state", 64'(state_dbg), 64'(ST_INIT));

        // Sweep: lookups and mispredicting updates every cycle must be ignored.
        for (int i = 0; i < PHT; i++)
            step(1, XLEN'($urandom), 1'($urandom_range(0, 1)), XLEN'($urandom),
                 GHSR_W'($urandom), 1, 1);
        check("sweep_ready", 64'(bus.ready), 64'(1));
        check("sweep_state", 64'(state_dbg), 64'(ST_RUN));
        check("sweep_count", 64'(bus.mispredict_count), 64'(0));
        check("sweep_ghsr", 64'(bus.predict_ghsr), 64'(0));
        for (int i = 0; i < 4; i++) step(1, XLEN'($urandom), 0, '0, '0, 0, 0);
        check("first_lookups_ghsr", 64'(bus.predict_ghsr), 64'(0));

        // Train pc=0x100 with ghsr=0 twice, then predict taken.
        step(0, '0, 1, 32'h100, '0, 1, 0);
        step(0, '0, 1, 32'h100, '0, 1, 0);
        check("train_ghsr_unchanged", 64'(bus.predict_ghsr), 64'(0));
        step(1, 32'h100, 0, '0, '0, 0, 0);
        check("train_ghsr_shift", 64'(bus.predict_ghsr), 64'(1));

        // Saturation both ways on one entry, probing after every update.
        for (int i = 0; i < 5; i++) begin update_at(12'h155, 1, 0, '0); lookup_at(12'h155); end
        for (int i = 0; i < 5; i++) begin update_at(12'h155, 0, 0, '0); lookup_at(12'h155); end

        // Same-cycle update and lookup of one entry: no bypass.
        step(1, XLEN'(((12'h2AA ^ int'(m_ghsr)) & (PHT - 1)) << 2),
             1, XLEN'(12'h2AA << 2), '0, 1, 0);
        lookup_at(12'h2AA);

        // Speculation: history 0, then predictions 1,0,1 give 0x005.
        update_at(12'h03A, 1, 0, '0); update_at(12'h03A, 1, 0, '0);
        update_at(12'h03C, 1, 0, '0); update_at(12'h03C, 1, 0, '0);
        update_at(12'h3F0, 0, 1, '0);
        check("spec_ghsr_zero", 64'(bus.predict_ghsr), 64'(0));
        check("spec_count", 64'(bus.mispredict_count), 64'(1));
        lookup_at(12'h03A); lookup_at(12'h03B); lookup_at(12'h03C);
        check("spec_ghsr", 64'(bus.predict_ghsr), 64'h005);

        // Recovery overrides a same-cycle speculative shift.
        step(1, XLEN'($urandom), 1, 32'h0000_0480, 10'h0A0, 1, 1);
        check("recover_ghsr", 64'(bus.predict_ghsr), 64'h141);
        check("recover_count", 64'(bus.mispredict_count), 64'(2));
        step(0, '0, 0, 32'h0000_0480, 10'h0A0, 1, 1);
        check("mispredict_no_valid", 64'(bus.mispredict_count), 64'(2));

        for (int i = 0; i < 400; i++) random_step();
        check("random_count", 64'(bus.mispredict_count), 64'(m_count));

        // Reset in mid-sweep restarts it; an update during the sweep is dropped.
        do_reset();
        for (int i = 0; i < 500; i++) step(1, XLEN'($urandom), 0, '0, '0, 0, 0);
        do_reset();
        check("rerst_ready", 64'(bus.ready), 64'(0));
        check("rerst_ghsr", 64'(bus.predict_ghsr), 64'(0));
        for (int i = 0; i < PHT; i++) begin
            if (i == 100) update_at(12'h077, 1, 1, '0);
            else step(1, XLEN'($urandom), 0, '0, '0, 0, 0);
        end
        check("rerst_ready_after", 64'(bus.ready), 64'(1));
        check("rerst_count", 64'(bus.mispredict_count), 64'(0));
        lookup_at(12'h077);
        update_at(12'h077, 1, 0, '0);
        lookup_at(12'h077);

        idle(2);
        @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
